// File: rtl/iob2axi_wr_seq_if.sv
// Control interface between the burst sequencer (master) and the iob2axi_wr engine (slave).
interface iob2axi_wr_seq_if #(
  parameter int ADDR_W    = 32,
  parameter int AXI_LEN_W = 8
);
  logic                 wr_run;
  logic [ADDR_W-1:0]    wr_addr;
  logic [AXI_LEN_W-1:0] wr_length;
  logic                 wr_ready;
  logic                 wr_error;

  modport master (output wr_run, wr_addr, wr_length, input  wr_ready, wr_error);
  modport slave  (input  wr_run, wr_addr, wr_length, output wr_ready, wr_error);
endinterface

// File: rtl/iob2axi_wr_seq.sv
// Splits one long write into AXI4 INCR bursts (<= MAX_BURST beats, no 4 KB crossing),
// issues them to the iob2axi_wr engine one at a time and aggregates their status.
module iob2axi_wr_seq #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_LEN_W = 8,
  parameter int MAX_BURST = 256,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  n_words,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  burst_cnt,
  iob2axi_wr_seq_if.master  wr
);
  localparam int B     = DATA_W / 8;
  localparam int OFF   = $clog2(B);
  localparam int BW    = AXI_LEN_W + 1;
  localparam int MW0   = (CNT_W > 13) ? CNT_W : 13;
  localparam int MW    = (MW0 > BW) ? MW0 : BW;

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT_ACK, WAIT_DONE, DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic                 error_q, error_d;
  logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [AXI_LEN_W-1:0] wr_length_q, wr_length_d;
  logic                 run;

  logic [12:0]          to_bnd;
  logic [MW-1:0]        rem_ext, bnd_ext, max_ext, beats_m;
  logic [BW-1:0]        beats;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      rem_q       <= '0;
      error_q     <= 1'b0;
      burst_cnt_q <= '0;
      wr_addr_q   <= '0;
      wr_length_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rem_q       <= rem_d;
      error_q     <= error_d;
      burst_cnt_q <= burst_cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_length_q <= wr_length_d;
    end
  end

  // Burst size: the smallest of remaining words, MAX_BURST and words left in this 4 KB page.
  always_comb begin
    to_bnd  = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> OFF;
    rem_ext = MW'(rem_q);
    bnd_ext = MW'(to_bnd);
    max_ext = MW'(MAX_BURST);
    beats_m = rem_ext;
    if (max_ext < beats_m) beats_m = max_ext;
    if (bnd_ext < beats_m) beats_m = bnd_ext;
    beats   = BW'(beats_m);
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    rem_d       = rem_q;
    error_d     = error_q;
    burst_cnt_d = burst_cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_length_d = wr_length_q;
    run         = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        cur_addr_d  = base_addr & ~ADDR_W'(B - 1);
        rem_d       = n_words;
        error_d     = 1'b0;
        burst_cnt_d = '0;
        state_d     = (n_words == '0) ? DONE : CALC;
      end
      CALC: begin
        wr_addr_d   = cur_addr_q;
        wr_length_d = AXI_LEN_W'(beats - BW'(1));
        rem_d       = rem_q - CNT_W'(beats);
        cur_addr_d  = cur_addr_q + (ADDR_W'(beats) << OFF);
        state_d     = ISSUE;
      end
      ISSUE: if (wr.wr_ready) begin
        run     = 1'b1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: if (!wr.wr_ready) state_d = WAIT_DONE;
      // A failed burst is only recorded; the rest of the transfer still goes out.
      WAIT_DONE: if (wr.wr_ready) begin
        error_d     = error_q | wr.wr_error;
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
        state_d     = (rem_q == '0) ? DONE : CALC;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign error        = error_q;
  assign burst_cnt    = burst_cnt_q;
  assign wr.wr_run    = run;
  assign wr.wr_addr   = wr_addr_q;
  assign wr.wr_length = wr_length_q;
endmodule

// File: tb/tb_iob2axi_wr_seq.sv
// Directed + random bench for iob2axi_wr_seq with a small engine model and a burst-split reference.
module tb_iob2axi_wr_seq;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] n_words = '0;
  logic        busy, done, error;
  logic [15:0] burst_cnt;
  logic        eng_rdy = 1'b1, eng_err = 1'b0, hold = 1'b0;

  iob2axi_wr_seq_if #(.ADDR_W(32), .AXI_LEN_W(8)) wr_if ();
  assign wr_if.wr_ready = eng_rdy & ~hold;
  assign wr_if.wr_error = eng_err;

  iob2axi_wr_seq #(.ADDR_W(32), .DATA_W(32), .AXI_LEN_W(8), .MAX_BURST(256), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .n_words(n_words),
    .busy(busy), .done(done), .error(error), .burst_cnt(burst_cnt), .wr(wr_if));

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int bursts_seen = 0, err_idx = -1, lat_fix = 0, eng_idx = 0;
  logic [31:0] obs_addr[$], exp_addr[$];
  logic [7:0]  obs_len[$],  exp_len[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Engine model: takes a run, drops ready for a few cycles, then reports status.
  initial begin
    forever begin
      @(negedge clk);
      if (wr_if.wr_run === 1'b1) begin
        chk("run_needs_ready", 64'(wr_if.wr_ready), 64'd1);
        obs_addr.push_back(wr_if.wr_addr);
        obs_len.push_back(wr_if.wr_length);
        eng_idx = bursts_seen;
        bursts_seen++;
        @(posedge clk); #1;
        eng_rdy = 1'b0; eng_err = 1'b0;
        repeat ((lat_fix > 0) ? lat_fix : int'($urandom_range(4, 1))) @(posedge clk);
        #1;
        eng_rdy = 1'b1; eng_err = (eng_idx == err_idx);
      end
    end
  end

  // Reference split: walk the transfer word-aligned, cutting at 256 beats and 4 KB pages.
  task automatic model(input logic [31:0] base, input int n);
    logic [31:0] a;
    int r, pg, b;
    exp_addr.delete(); exp_len.delete();
    a = base & 32'hFFFF_FFFC;
    r = n;
    while (r > 0) begin
      pg = (4096 - int'(a[11:0])) / 4;
      b = r;
      if (b > 256) b = 256;
      if (b > pg)  b = pg;
      exp_addr.push_back(a);
      exp_len.push_back(8'(b - 1));
      a = a + 32'(b * 4);
      r = r - b;
    end
  endtask

  task automatic start_xfer(input logic [31:0] base, input int n);
    @(negedge clk);
    bursts_seen = 0;
    obs_addr.delete(); obs_len.delete();
    start = 1'b1; base_addr = base; n_words = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_xfer(input logic [31:0] base, input int n, input string tag);
    bit got, exp_err;
    int m;
    model(base, n);
    exp_err = (err_idx >= 0) && (err_idx < exp_addr.size());
    got = 1'b0;
    for (int c = 0; c < 5000 && !got; c++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    chk({tag, "_burst_cnt"}, 64'(burst_cnt), 64'(exp_addr.size()));
    chk({tag, "_error"}, 64'(error), 64'(exp_err));
    chk({tag, "_n_bursts"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
    m = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(obs_addr[i]), 64'(exp_addr[i]));
      chk($sformatf("%s_len%0d", tag, i), 64'(obs_len[i]), 64'(exp_len[i]));
    end
    @(negedge clk);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_done"}, 64'(done), 64'd0);
    chk({tag, "_held_cnt"}, 64'(burst_cnt), 64'(exp_addr.size()));
    chk({tag, "_held_err"}, 64'(error), 64'(exp_err));
  endtask

  initial begin
    bit any_run, got;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_cnt", 64'(burst_cnt), 64'd0);
    chk("rst_run", 64'(wr_if.wr_run), 64'd0);
    chk("rst_addr", 64'(wr_if.wr_addr), 64'd0);
    chk("rst_len", 64'(wr_if.wr_length), 64'd0);
    rst = 1'b1;

    // single burst, first-run latency
    start_xfer(32'h1000, 16);
    @(negedge clk);
    chk("t1_calc_norun", 64'(wr_if.wr_run), 64'd0);
    chk("t1_calc_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t1_issue_run", 64'(wr_if.wr_run), 64'd1);
    chk("t1_issue_addr", 64'(wr_if.wr_addr), 64'h1000);
    chk("t1_issue_len", 64'(wr_if.wr_length), 64'd15);
    finish_xfer(32'h1000, 16, "t1");

    start_xfer(32'h0, 600);    finish_xfer(32'h0, 600, "t2");
    start_xfer(32'h0FF0, 10);  finish_xfer(32'h0FF0, 10, "t3");

    // error on burst 2 of 3, then a clean transfer clears it
    err_idx = 1;
    start_xfer(32'h0, 600);    finish_xfer(32'h0, 600, "t4err");
    err_idx = -1;
    start_xfer(32'h40, 4);
    chk("t4_err_cleared", 64'(error), 64'd0);
    finish_xfer(32'h40, 4, "t4clr");

    // zero-length transfer
    start_xfer(32'h3000, 0);
    @(negedge clk);
    chk("t5z_done", 64'(done), 64'd1);
    chk("t5z_busy", 64'(busy), 64'd1);
    chk("t5z_cnt", 64'(burst_cnt), 64'd0);
    @(negedge clk);
    chk("t5z_idle", 64'(busy), 64'd0);
    chk("t5z_norun", 64'(obs_addr.size()), 64'd0);

    // engine not ready for 5 cycles at ISSUE
    hold = 1'b1;
    start_xfer(32'h2000, 4);
    any_run = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (wr_if.wr_run !== 1'b0) any_run = 1'b1;
    end
    chk("t5h_no_run_held", 64'(any_run), 64'd0);
    @(posedge clk); #1;
    hold = 1'b0;
    @(negedge clk);
    chk("t5h_run_release", 64'(wr_if.wr_run), 64'd1);
    finish_xfer(32'h2000, 4, "t5h");

    // start while busy is ignored
    start_xfer(32'h0, 600);
    repeat (5) @(negedge clk);
    start = 1'b1; base_addr = 32'h8000; n_words = 16'd16;
    @(negedge clk);
    start = 1'b0;
    finish_xfer(32'h0, 600, "t6busy");

    // async reset during WAIT_DONE of burst 2
    err_idx = 0; lat_fix = 8;
    start_xfer(32'h0, 600);
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (obs_addr.size() == 2) got = 1'b1;
    end
    chk("t6r_second_run", 64'(got), 64'd1);
    repeat (3) @(negedge clk);
    chk("t6r_pre_busy", 64'(busy), 64'd1);
    chk("t6r_pre_err", 64'(error), 64'd1);
    chk("t6r_pre_cnt", 64'(burst_cnt), 64'd1);
    chk("t6r_pre_addr", 64'(wr_if.wr_addr), 64'h400);
    #2 rst = 1'b0;
    #1;
    chk("t6r_busy", 64'(busy), 64'd0);
    chk("t6r_done", 64'(done), 64'd0);
    chk("t6r_error", 64'(error), 64'd0);
    chk("t6r_cnt", 64'(burst_cnt), 64'd0);
    chk("t6r_run", 64'(wr_if.wr_run), 64'd0);
    chk("t6r_addr", 64'(wr_if.wr_addr), 64'd0);
    chk("t6r_len", 64'(wr_if.wr_length), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    err_idx = -1; lat_fix = 0;
    repeat (15) @(negedge clk);
    start_xfer(32'h5004, 20);  finish_xfer(32'h5004, 20, "t6recover");

    // random transfers against the reference split
    for (int k = 0; k < 6; k++) begin
      logic [31:0] rb;
      int rn;
      rb = $urandom;
      rn = int'($urandom_range(1500, 1));
      err_idx = int'($urandom_range(4, 0)) - 1;
      start_xfer(rb, rn);
      finish_xfer(rb, rn, $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/iob2axi_wr_seq.md
# iob2axi_wr_seq

Burst sequencer that sits in front of the iob2axi_wr engine and drives its control interface (run/addr/length/ready/error). It accepts one long write transfer described by a base byte address and a word count. It splits the transfer into legal AXI4 INCR bursts of at most MAX_BURST beats that never cross a 4 KB boundary, and issues them back-to-back. The native data stream goes straight to the engine's slave port; this block only sequences bursts and aggregates their status.

## Interface
Parameters:
- ADDR_W, 32: byte-address width; same as the engine's AXI_ADDR_W.
- DATA_W, 32: data width; bytes per word B = DATA_W/8, a power of two.
- AXI_LEN_W, 8: AXI burst-length field width.
- MAX_BURST, 256: maximum beats per burst; must be ≤ 2^AXI_LEN_W.
- CNT_W, 16: width of the total word count.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  transfer request; sampled only in IDLE.
- base_addr  in  ADDR_W  start byte address; the low log2(B) bits are forced to 0.
- n_words  in  CNT_W  total words to write; 0 is legal.
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse when the transfer is complete.
- error  out  1  sticky OR of all burst errors in the current transfer; cleared on an accepted start.
- burst_cnt  out  CNT_W  number of bursts completed in the current transfer.
- wr_run  out  1  engine run strobe.
- wr_addr  out  ADDR_W  burst start address to the engine.
- wr_length  out  AXI_LEN_W  beats−1 to the engine.
- wr_ready  in  1  engine idle/ready.
- wr_error  in  1  engine error; valid while wr_ready=1.

## Operation
States: IDLE, CALC, ISSUE, WAIT_ACK, WAIT_DONE, DONE.

- **IDLE:** busy=0.
  - start=1 latches cur_addr (aligned base_addr) and rem=n_words, clears error and burst_cnt.
  - Goes to DONE if n_words=0, otherwise to CALC.
- **CALC:** computes the next burst and registers it.
  - to_bnd = (4096 − cur_addr[11:0]) / B.
  - beats = min(rem, MAX_BURST, to_bnd). beats is at least 1 by construction.
  - Registers wr_addr=cur_addr and wr_length=beats−1.
  - Updates rem −= beats and cur_addr += beats·B, modulo 2^ADDR_W.
  - Goes to ISSUE.
- **ISSUE:** wr_run = wr_ready. When wr_ready=1, wr_run is high for exactly that one cycle, then the state goes to WAIT_ACK. Otherwise the block holds with wr_run=0.
- **WAIT_ACK:** waits for wr_ready=0, which is the engine accepting the burst, then goes to WAIT_DONE.
- **WAIT_DONE:** waits for wr_ready=1. On that cycle:
  - error |= wr_error;
  - burst_cnt += 1;
  - goes to DONE if rem=0, otherwise to CALC.
- **DONE:** done=1 for one cycle, busy=1, then IDLE.
- A burst error does not abort the transfer; the remaining bursts are still issued.
- start outside IDLE is ignored.
- wr_addr and wr_length stay stable from CALC until the next CALC, because the engine latches them on every idle cycle.

## Timing
- Reset (rst=0) values: state=IDLE, busy=0, done=0, error=0, burst_cnt=0, wr_run=0, wr_addr=0, wr_length=0. Internal rem and cur_addr are also 0.
- Reset mid-transfer returns to IDLE immediately. Any burst already in flight in the engine is not tracked.
- Cycle sequence with start accepted at edge t:
  - CALC during t+1.
  - wr_run during t+2 at the earliest, if wr_ready=1.
- Burst turnaround is the engine's response time plus 3 cycles: WAIT_DONE→CALC→ISSUE.
- wr_run is never high in any state other than ISSUE, and never while wr_ready=0.
- error and burst_cnt remain valid after done until the next accepted start.
- Arithmetic:
  - to_bnd needs 13 bits before the divide.
  - beats needs AXI_LEN_W+1 bits.
  - rem is CNT_W bits and never underflows.

## Test plan
1. DATA_W=32, base 0x1000, n_words=16 → one run, wr_addr=0x1000, wr_length=15; done pulses; burst_cnt=1; error=0.
2. base 0x0, n_words=600 → three bursts:
   - 0x000 with length 255;
   - 0x400 with length 255;
   - 0x800 with length 87.
   Result: burst_cnt=3.
3. 4 KB crossing, base 0x0FF0, n_words=10 → two bursts:
   - 0x0FF0 with length 3;
   - 0x1000 with length 5.
4. Engine model reports an error on burst 2 of 3 → all 3 bursts are issued and error=1 at done. A following start with n_words=4 clears error, and it stays 0.
5. n_words=0 → done two cycles after start, no wr_run, burst_cnt=0. Hold wr_ready=0 for 5 cycles at ISSUE → wr_run is delayed until wr_ready=1.
6. start pulsed while busy → ignored, no extra bursts. rst=0 asserted during WAIT_DONE → all outputs take their reset values asynchronously.
